// File: rtl/fp_normalize_if.sv
// fp_normalize_if -- handshake and data bundle between the FP adder, the
// normalizer and the exception-check stage.
//   in_valid/in_ready   : upstream handshake for sum_frac/exp_in/s_in
//   sum_frac[24:0]      : raw significand sum (24 carry, 23 hidden one)
//   exp_in[7:0], s_in   : biased exponent of the larger operand, result sign
//   out_valid/out_ready : downstream handshake for frac/exp/s
//   frac[31:0]          : normalized significand in [23:0], [31:24] zero
//   exp[7:0], s         : saturated biased exponent, sign
// Modports: master = producer/consumer side (testbench or neighbours),
//           slave  = the normalizer itself.
interface fp_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] sum_frac;
  logic [7:0]  exp_in;
  logic        s_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] frac;
  logic [7:0]  exp;
  logic        s;

  modport master (
    output in_valid, sum_frac, exp_in, s_in, out_ready,
    input  in_ready, out_valid, frac, exp, s
  );

  modport slave (
    input  in_valid, sum_frac, exp_in, s_in, out_ready,
    output in_ready, out_valid, frac, exp, s
  );
endinterface

// File: rtl/fp_normalize.sv
// fp_normalize -- post-add normalization of an FP32 significand sum.
// Accepts one raw sum, then normalizes it one step per cycle: a carry out
// is absorbed by a single right shift, leading zeros are removed by left
// shifts one bit per cycle, with exponent saturation to 255 and flush to
// zero on underflow. The result is held until the downstream accepts it.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   b   - fp_normalize_if.slave (input/output handshakes and data)
// Compile option:
//   NORM_ROUND_EN - the carry right shift rounds to nearest even instead
//                   of truncating; a rounding carry costs one more step.
module fp_normalize (
  input  logic              clk,
  input  logic              rst,
  fp_normalize_if.slave     b
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state;
  logic [24:0] w;         // working significand, carry in bit 24
  logic [7:0]  e;         // working exponent
  logic        sg;
  logic        in_rdy_r;
  logic        out_vld_r;
  logic [24:0] rs;        // significand after the carry right shift

`ifdef NORM_ROUND_EN
  // Round half to even: increment when the dropped bit and the new LSB are 1.
  always_comb begin
    rs = {1'b0, w[24:1]} + {24'd0, w[0] & w[1]};
  end
`else
  always_comb begin
    rs = {1'b0, w[24:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_rdy_r  <= 1'b1;
      out_vld_r <= 1'b0;
      w         <= '0;
      e         <= '0;
      sg        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (b.in_valid) begin
            w        <= b.sum_frac;
            e        <= b.exp_in;
            sg       <= b.s_in;
            in_rdy_r <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          if (w == 25'd0) begin
            e         <= 8'd0;
            out_vld_r <= 1'b1;
            state     <= DONE;
          end else if (e == 8'hFF) begin
            w         <= '0;
            out_vld_r <= 1'b1;
            state     <= DONE;
          end else if (w[24]) begin
            if (e >= 8'hFE) begin
              // exponent would reach 255: saturate to infinity
              w         <= '0;
              e         <= 8'hFF;
              out_vld_r <= 1'b1;
              state     <= DONE;
            end else begin
              w <= rs;
              e <= e + 8'd1;
              // rs[24] can only be set by a rounding carry; take another step
              if (!rs[24]) begin
                out_vld_r <= 1'b1;
                state     <= DONE;
              end
            end
          end else if (w[23]) begin
            out_vld_r <= 1'b1;
            state     <= DONE;
          end else if (e <= 8'd1) begin
            // cannot shift further without going subnormal: flush to zero
            w         <= '0;
            e         <= 8'd0;
            out_vld_r <= 1'b1;
            state     <= DONE;
          end else begin
            w <= {w[23:0], 1'b0};
            e <= e - 8'd1;
          end
        end
        DONE: begin
          if (b.out_ready) begin
            out_vld_r <= 1'b0;
            in_rdy_r  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_rdy_r  <= 1'b1;
          out_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign b.in_ready  = in_rdy_r;
  assign b.out_valid = out_vld_r;
  assign b.frac      = {8'd0, w[23:0]};
  assign b.exp       = e;
  assign b.s         = sg;
endmodule

// File: tb/tb_fp_normalize.sv
module tb_fp_normalize;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_normalize_if bus();
  fp_normalize dut (.clk(clk), .rst(rst), .b(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [24:0] sf;
    logic [7:0]  ei;
    logic        si;
    logic [31:0] ef;
    logic [7:0]  ee;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [24:0] sf, input logic [7:0] ei, input logic si,
                     input logic [31:0] ef, input logic [7:0] ee, input int lat);
    vec_t x;
    x.sf = sf; x.ei = ei; x.si = si; x.ef = ef; x.ee = ee; x.lat = lat;
    vt.push_back(x);
  endtask

  // Waits for in_ready, presents one result for one cycle and returns the
  // number of negedges from the accepting edge until out_valid is seen.
  task automatic send(input logic [24:0] sf, input logic [7:0] ei, input logic si,
                      output int lat);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready before send", {31'd0, bus.in_ready}, 32'd1);
    bus.sum_frac = sf;
    bus.exp_in   = ei;
    bus.s_in     = si;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid after release", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready after release", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] f0;
    logic [7:0]  e0;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum_frac  = '0;
    bus.exp_in    = '0;
    bus.s_in      = 1'b0;

    add(25'h1800000, 8'h80, 1'b0, 32'h00C00000, 8'h81, 2);  // carry
    add(25'h0200000, 8'h80, 1'b1, 32'h00800000, 8'h7E, 4);  // two left shifts
    add(25'h1000000, 8'hFE, 1'b0, 32'h00000000, 8'hFF, 2);  // carry overflow
    add(25'h0000001, 8'h05, 1'b0, 32'h00000000, 8'h00, 6);  // underflow flush
    add(25'h0000000, 8'h40, 1'b1, 32'h00000000, 8'h00, 2);  // zero
    add(25'h0800000, 8'h7F, 1'b0, 32'h00800000, 8'h7F, 2);  // already normal
    add(25'h0ABCDEF, 8'hFF, 1'b1, 32'h00000000, 8'hFF, 2);  // exp 255
    add(25'h0000001, 8'h80, 1'b0, 32'h00800000, 8'h69, 25); // max latency
    add(25'h0400000, 8'h02, 1'b0, 32'h00800000, 8'h01, 3);  // lands on exp 1
    add(25'h0400000, 8'h01, 1'b1, 32'h00000000, 8'h00, 2);  // exp 1 flush
    add(25'h1800001, 8'h80, 1'b0, 32'h00C00000, 8'h81, 2);  // tie, even LSB
`ifdef NORM_ROUND_EN
    add(25'h1FFFFFF, 8'h80, 1'b0, 32'h00800000, 8'h82, 3);
    add(25'h1000003, 8'h10, 1'b1, 32'h00800002, 8'h11, 2);
`else
    add(25'h1FFFFFF, 8'h80, 1'b0, 32'h00FFFFFF, 8'h81, 2);
    add(25'h1000003, 8'h10, 1'b1, 32'h00800001, 8'h11, 2);
`endif

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset frac", bus.frac, 32'd0);
    chk("reset exp", {24'd0, bus.exp}, 32'd0);
    chk("reset s", {31'd0, bus.s}, 32'd0);

    foreach (vt[i]) begin
      send(vt[i].sf, vt[i].ei, vt[i].si, lat);
      chk($sformatf("v%0d latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d frac", i), bus.frac, vt[i].ef);
      chk($sformatf("v%0d exp", i), {24'd0, bus.exp}, {24'd0, vt[i].ee});
      chk($sformatf("v%0d s", i), {31'd0, bus.s}, {31'd0, vt[i].si});
      release_out();
    end

    // backpressure: hold DONE five cycles with in_valid also asserted
    send(25'h1800000, 8'h80, 1'b1, lat);
    chk("bp latency", lat, 2);
    f0 = bus.frac;
    e0 = bus.exp;
    chk("bp frac", f0, 32'h00C00000);
    bus.in_valid = 1'b1;
    bus.sum_frac = 25'h0800000;
    bus.exp_in   = 8'h33;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("bp%0d frac", c), bus.frac, 32'h00C00000);
      chk($sformatf("bp%0d exp", c), {24'd0, bus.exp}, 32'h81);
    end
    // release while in_valid stays high: the release cycle must not accept
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp idle in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp idle out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp idle exp kept", {24'd0, bus.exp}, 32'h81);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp next accept in_ready", {31'd0, bus.in_ready}, 32'd0);
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (bus.out_valid) seen = 1;
      else @(negedge clk);
    end
    chk("bp next out_valid", seen, 1);
    chk("bp next exp", {24'd0, bus.exp}, 32'h33);
    release_out();

    // reset in the middle of a long shift sequence
    @(negedge clk);
    bus.sum_frac = 25'h0000001;
    bus.exp_in   = 8'h80;
    bus.s_in     = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid-norm in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst mid frac", bus.frac, 32'd0);
    chk("rst mid exp", {24'd0, bus.exp}, 32'd0);
    chk("rst mid s", {31'd0, bus.s}, 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("rst mid no out_valid", seen, 0);

    // reset wins over an in_valid in the same cycle
    bus.in_valid = 1'b1;
    bus.sum_frac = 25'h0800000;
    rst = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; bus.in_valid = 1'b0; end
    @(negedge clk);
    chk("rst prio in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("rst prio no out_valid", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_normalize.md
FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL expose clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL expose rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL expose in_valid, input, 1, upstream adder result valid.
REQ-004 SHALL expose in_ready, output, 1, block can accept a result.
REQ-005 SHALL expose sum_frac, input, 25, raw significand sum: bit 24 is carry, bit 23 is hidden one, bits 22:0 are mantissa.
REQ-006 SHALL expose exp_in, input, 8, biased exponent of the larger operand.
REQ-007 SHALL expose s_in, input, 1, result sign.
REQ-008 SHALL expose out_valid, output, 1, normalized result valid toward exception check.
REQ-009 SHALL expose out_ready, input, 1, downstream accepts result.
REQ-010 SHALL expose frac, output, 32, normalized significand in bits 23:0 (bit 23 hidden one), bits 31:24 zero.
REQ-011 SHALL expose exp, output, 8, biased exponent, saturated to 255 on overflow and 0 on underflow.
REQ-012 SHALL expose s, output, 1, sign, passed unchanged from s_in.

Function
REQ-013 SHALL implement FSM states IDLE, NORM, DONE.
REQ-014 IDLE SHALL assert in_ready=1 and out_valid=0; on in_valid=1 it SHALL register sum_frac, exp_in, s_in and go to NORM.
REQ-015 NORM and DONE SHALL hold in_ready=0.
REQ-016 NORM, registered frac==0: exp:=0 -> DONE.
REQ-017 NORM, exp==255: frac:=0, exp:=255 -> DONE.
REQ-018 NORM, bit 24 set: shift right 1, exp:=exp+1 -> DONE; exp+1>=255 SHALL yield exp=255, frac=0.
REQ-019 NORM, bit 23 set, bit 24 clear -> DONE, unchanged.
REQ-020 NORM, bits 24:23 clear, exp<=1: frac:=0, exp:=0 -> DONE (underflow flush).
REQ-021 Otherwise NORM SHALL shift left 1, exp:=exp-1, stay in NORM.
REQ-022 Rules REQ-016..REQ-021 SHALL be evaluated in that priority order, one action per cycle.
REQ-023 DONE SHALL assert out_valid=1 with frac/exp/s stable until out_ready=1, then go to IDLE the next cycle.
REQ-024 Latency: out_valid SHALL rise 2 cycles after the accepting cycle plus one cycle per left shift; maximum 25 cycles.
REQ-025 No new input SHALL be accepted in the cycle DONE is released; the next accept occurs in IDLE.

Reset
REQ-026 rst=1 SHALL force IDLE, in_ready=1, out_valid=0, frac=0, exp=0, s=0 on the next edge.
REQ-027 rst during NORM or DONE SHALL discard the operation in flight; no out_valid SHALL follow.
REQ-028 rst SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-029 Macro NORM_ROUND_EN SHALL be the only compile option.
REQ-030 With NORM_ROUND_EN defined, the REQ-018 right shift SHALL round to nearest even: add 1 when the dropped bit and the new LSB are both 1.
REQ-031 Under NORM_ROUND_EN, if rounding sets bit 24 again, the FSM SHALL stay in NORM for one more REQ-018 step (+1 cycle).
REQ-032 Without NORM_ROUND_EN, the right shift SHALL truncate the dropped bit and latency SHALL be exactly REQ-024.

Verification
REQ-033 Carry case: sum_frac=0x1800000, exp_in=0x80 -> frac=0x00C00000, exp=0x81, out_valid 2 cycles after accept.
REQ-034 Left shift: sum_frac=0x0200000 (bit 21), exp_in=0x80 -> frac=0x00800000, exp=0x7E, out_valid 4 cycles after accept.
REQ-035 Limits: exp_in=0xFE with bit 24 set -> exp=0xFF, frac=0; sum_frac=0x0000001, exp_in=0x05 -> exp=0, frac=0; sum_frac=0 -> exp=0, frac=0.
REQ-036 Backpressure: out_ready low 5 cycles in DONE -> outputs stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-NORM: rst pulse during shift sequence -> IDLE next edge, out_valid never asserted.
REQ-038 Rounding, NORM_ROUND_EN on: sum_frac=0x1FFFFFF, exp_in=0x80 -> frac=0x00800000, exp=0x82, one extra cycle; off: frac=0x00FFFFFF, exp=0x81.
